// File: rtl/dist_pkg.sv
// -----------------------------------------------------------------------------
// dist_pkg
// Shared definitions for the distance datapath: the square-root FSM state
// encoding and the sum/root widths agreed between the accumulator, the
// controller and the square-root unit.
// No ports (package).
// -----------------------------------------------------------------------------
package dist_pkg;

   localparam int DIST_SUM_WIDTH  = 32;
   localparam int DIST_ROOT_WIDTH = 16;

   typedef enum logic [1:0] {
      SQ_IDLE = 2'd0,
      SQ_CALC = 2'd1,
      SQ_DONE = 2'd2
   } sq_state_t;

endpackage : dist_pkg

// File: rtl/sqrt_iter_step.sv
// -----------------------------------------------------------------------------
// sqrt_iter_step
// One combinational step of the restoring digit-by-digit square root: brings
// down the next two radicand bits, trial-subtracts {root,01} and appends the
// resulting root bit.
// Ports:
//   i_rem       [W+1:0]  current partial remainder
//   i_root      [W-1:0]  current partial root
//   i_bits      [1:0]    next two radicand bits (MSB first)
//   o_rem_next  [W+1:0]  remainder after this step
//   o_root_next [W-1:0]  root after this step
// -----------------------------------------------------------------------------
module sqrt_iter_step #(
   parameter int W = 16
) (
   input  logic [W+1:0] i_rem,
   input  logic [W-1:0] i_root,
   input  logic [1:0]   i_bits,
   output logic [W+1:0] o_rem_next,
   output logic [W-1:0] o_root_next
);

   logic [W+1:0] w_r2;
   logic [W+1:0] w_t;
   logic [W+1:0] w_diff;
   logic         w_take;

   // The remainder is bounded by 2*root+1, so its top two bits are always zero
   // when they would be shifted out here.
   logic w_unused_rem_hi;
   assign w_unused_rem_hi = ^i_rem[W+1:W];

   assign w_r2   = {i_rem[W-1:0], i_bits};
   assign w_t    = {i_root, 2'b01};
   assign w_take = (w_r2 >= w_t);
   assign w_diff = w_r2 - w_t;

   always_comb begin
      o_rem_next  = w_r2;
      o_root_next = {i_root[W-2:0], 1'b0};
      if (w_take) begin
         o_rem_next  = w_diff;
         o_root_next = {i_root[W-2:0], 1'b1};
      end
   end

endmodule : sqrt_iter_step

// File: rtl/dist_sqrt_unit.sv
// -----------------------------------------------------------------------------
// dist_sqrt_unit
// Iterative integer square root, floor(sqrt(DIN_Sqrt)), one root bit per clock.
// Level handshake: controller holds EN_Sqrt high until it sees RDY_Sqrt, then
// drops it; dropping EN_Sqrt mid-calculation aborts without a result.
// Ports:
//   clk        clock, all state on posedge
//   RST        synchronous active-high reset
//   EN_Sqrt    start/hold level from controller
//   DIN_Sqrt   [IN_WIDTH-1:0]   radicand, sampled only at the capture edge
//   RDY_Sqrt   result valid (registered)
//   DOUT_Sqrt  [IN_WIDTH/2-1:0] floor square root (registered, holds last result)
// -----------------------------------------------------------------------------
module dist_sqrt_unit
   import dist_pkg::*;
#(
   parameter int IN_WIDTH = DIST_SUM_WIDTH
) (
   input  logic                    clk,
   input  logic                    RST,
   input  logic                    EN_Sqrt,
   input  logic [IN_WIDTH-1:0]     DIN_Sqrt,
   output logic                    RDY_Sqrt,
   output logic [IN_WIDTH/2-1:0]   DOUT_Sqrt
);

   localparam int OUT_WIDTH = IN_WIDTH / 2;
   localparam int ITER_W    = $clog2(OUT_WIDTH) + 1;
   localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(OUT_WIDTH - 1);

   sq_state_t              r_state;
   logic [IN_WIDTH-1:0]    r_rad;
   logic [OUT_WIDTH+1:0]   r_rem;
   logic [OUT_WIDTH-1:0]   r_root;
   logic [ITER_W-1:0]      r_iter;
   logic                   r_rdy;
   logic [OUT_WIDTH-1:0]   r_dout;

   logic [OUT_WIDTH+1:0]   w_rem_next;
   logic [OUT_WIDTH-1:0]   w_root_next;

   sqrt_iter_step #(
      .W (OUT_WIDTH)
   ) u_step (
      .i_rem       (r_rem),
      .i_root      (r_root),
      .i_bits      (r_rad[IN_WIDTH-1:IN_WIDTH-2]),
      .o_rem_next  (w_rem_next),
      .o_root_next (w_root_next)
   );

   always_ff @(posedge clk) begin
      if (RST) begin
         r_state <= SQ_IDLE;
         r_rad   <= '0;
         r_rem   <= '0;
         r_root  <= '0;
         r_iter  <= '0;
         r_rdy   <= 1'b0;
         r_dout  <= '0;
      end else begin
         case (r_state)
            SQ_IDLE: begin
               r_rdy <= 1'b0;
               if (EN_Sqrt) begin
                  r_rad   <= DIN_Sqrt;
                  r_rem   <= '0;
                  r_root  <= '0;
                  r_iter  <= '0;
                  r_state <= SQ_CALC;
               end
            end
            SQ_CALC: begin
               if (!EN_Sqrt) begin
                  // Abort: no step on this edge, previous result is kept.
                  r_rdy   <= 1'b0;
                  r_state <= SQ_IDLE;
               end else begin
                  r_rem  <= w_rem_next;
                  r_root <= w_root_next;
                  r_rad  <= {r_rad[IN_WIDTH-3:0], 2'b00};
                  r_iter <= r_iter + ITER_W'(1);
                  if (r_iter == ITER_LAST) begin
                     r_dout  <= w_root_next;
                     r_rdy   <= 1'b1;
                     r_state <= SQ_DONE;
                  end
               end
            end
            SQ_DONE: begin
               // Stay here while EN is held; a new run needs EN low for an edge.
               if (!EN_Sqrt) begin
                  r_rdy   <= 1'b0;
                  r_state <= SQ_IDLE;
               end
            end
            default: begin
               r_rdy   <= 1'b0;
               r_state <= SQ_IDLE;
            end
         endcase
      end
   end

   assign RDY_Sqrt  = r_rdy;
   assign DOUT_Sqrt = r_dout;

endmodule : dist_sqrt_unit

// File: tb/tb_dist_sqrt_unit.sv
// -----------------------------------------------------------------------------
// tb_dist_sqrt_unit
// Self-checking bench for dist_sqrt_unit: reset, table of known roots, abort,
// hold-in-DONE, back-to-back, reset mid-calculation and random radicands
// checked against a floor-sqrt reference computed with plain arithmetic.
// -----------------------------------------------------------------------------
module tb_dist_sqrt_unit;

   logic        clk;
   logic        RST;
   logic        EN_Sqrt;
   logic [31:0] DIN_Sqrt;
   logic        RDY_Sqrt;
   logic [15:0] DOUT_Sqrt;

   int n_cmp;
   int n_err;

   typedef struct {
      logic [31:0] din;
      logic [15:0] dout;
   } vec_t;

   vec_t tbl [8];

   dist_sqrt_unit #(
      .IN_WIDTH (32)
   ) dut (
      .clk       (clk),
      .RST       (RST),
      .EN_Sqrt   (EN_Sqrt),
      .DIN_Sqrt  (DIN_Sqrt),
      .RDY_Sqrt  (RDY_Sqrt),
      .DOUT_Sqrt (DOUT_Sqrt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance past the next rising edge; inputs change and outputs are sampled here.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   // Reference: largest r with r*r <= x, by plain arithmetic.
   function automatic logic [15:0] ref_sqrt(input logic [31:0] x);
      longint xv;
      longint r;
      xv = longint'({32'd0, x});
      r  = longint'($sqrt(real'(xv)));
      while (r * r > xv) r--;
      while ((r + 1) * (r + 1) <= xv) r++;
      return r[15:0];
   endfunction

   // Full handshake: capture, expect RDY exactly 16 edges later, hold EN for
   // hold_cycles edges in DONE, then drop EN for one edge.
   task automatic run_vec(input logic [31:0] din, input logic [15:0] exp, input int hold_cycles);
      int lat;
      logic [15:0] dout_at_rdy;
      EN_Sqrt  = 1'b1;
      DIN_Sqrt = din;
      step();                               // E0
      check("rdy_after_capture", {31'd0, RDY_Sqrt}, 32'd0);
      DIN_Sqrt = $urandom;                  // must be ignored from here on
      lat = 0;
      for (int n = 1; n <= 24; n++) begin
         step();
         if (RDY_Sqrt === 1'b1) begin
            lat = n;
            break;
         end
      end
      check("latency", lat, 32'd16);
      check("dout", {16'd0, DOUT_Sqrt}, {16'd0, exp});
      dout_at_rdy = DOUT_Sqrt;
      $display("vec din=0x%08h dout=%0d expected=%0d latency=%0d", din, DOUT_Sqrt, exp, lat);
      for (int h = 0; h < hold_cycles; h++) begin
         step();
         check("hold_rdy", {31'd0, RDY_Sqrt}, 32'd1);
         check("hold_dout", {16'd0, DOUT_Sqrt}, {16'd0, dout_at_rdy});
      end
      EN_Sqrt = 1'b0;
      step();
      check("rdy_drop", {31'd0, RDY_Sqrt}, 32'd0);
      check("dout_kept_idle", {16'd0, DOUT_Sqrt}, {16'd0, dout_at_rdy});
   endtask

   initial begin
      logic [15:0] prior;
      logic [31:0] r;
      int          late_rdy;

      n_cmp = 0;
      n_err = 0;

      tbl[0] = '{din: 32'd144,        dout: 16'd12};
      tbl[1] = '{din: 32'd15,         dout: 16'd3};
      tbl[2] = '{din: 32'd0,          dout: 16'd0};
      tbl[3] = '{din: 32'd1,          dout: 16'd1};
      tbl[4] = '{din: 32'hFFFFFFFF,   dout: 16'hFFFF};
      tbl[5] = '{din: 32'hFFFE0001,   dout: 16'hFFFF};
      tbl[6] = '{din: 32'hFFFE0000,   dout: 16'hFFFE};
      tbl[7] = '{din: 32'd4,          dout: 16'd2};

      // Reset held with EN high: nothing captured.
      RST      = 1'b1;
      EN_Sqrt  = 1'b1;
      DIN_Sqrt = 32'd144;
      step();
      step();
      check("reset_rdy", {31'd0, RDY_Sqrt}, 32'd0);
      check("reset_dout", {16'd0, DOUT_Sqrt}, 32'd0);
      $display("reset rdy=%0b dout=%0d", RDY_Sqrt, DOUT_Sqrt);
      RST = 1'b0;

      // First capture directly after reset release (EN still high).
      run_vec(32'd144, 16'd12, 1);

      // Table vectors, each with the controller's one-cycle hold.
      for (int i = 0; i < 8; i++) begin
         run_vec(tbl[i].din, tbl[i].dout, 1);
      end

      // Abort: drop EN at the 5th CALC edge.
      prior    = DOUT_Sqrt;
      EN_Sqrt  = 1'b1;
      DIN_Sqrt = 32'd1000000;
      step();                               // E0
      for (int k = 0; k < 4; k++) step();   // CALC edges 1..4
      EN_Sqrt = 1'b0;
      step();                               // 5th CALC edge -> abort
      check("abort_rdy", {31'd0, RDY_Sqrt}, 32'd0);
      check("abort_dout", {16'd0, DOUT_Sqrt}, {16'd0, prior});
      late_rdy = 0;
      for (int k = 0; k < 20; k++) begin
         step();
         if (RDY_Sqrt === 1'b1) late_rdy++;
      end
      check("abort_no_late_rdy", late_rdy, 32'd0);
      $display("abort dout=%0d prior=%0d late_rdy=%0d", DOUT_Sqrt, prior, late_rdy);
      run_vec(32'd1000000, 16'd1000, 1);

      // Hold 4 cycles in DONE, then back-to-back with a single low EN edge.
      run_vec(32'd2025, 16'd45, 4);
      run_vec(32'd49, 16'd7, 1);

      // Reset at the 8th CALC step.
      EN_Sqrt  = 1'b1;
      DIN_Sqrt = 32'd987654321;
      step();                               // E0
      for (int k = 0; k < 7; k++) step();
      RST = 1'b1;
      step();
      check("midreset_rdy", {31'd0, RDY_Sqrt}, 32'd0);
      check("midreset_dout", {16'd0, DOUT_Sqrt}, 32'd0);
      RST     = 1'b0;
      EN_Sqrt = 1'b0;
      late_rdy = 0;
      for (int k = 0; k < 20; k++) begin
         step();
         if (RDY_Sqrt === 1'b1) late_rdy++;
      end
      check("midreset_no_late_rdy", late_rdy, 32'd0);
      $display("midreset rdy=%0b dout=%0d late_rdy=%0d", RDY_Sqrt, DOUT_Sqrt, late_rdy);

      // Random radicands against the reference; mix of full-range and small values.
      for (int i = 0; i < 30; i++) begin
         r = $urandom;
         if (i % 3 == 1) r = r >> $urandom_range(31, 8);
         run_vec(r, ref_sqrt(r), $urandom_range(2, 1));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_dist_sqrt_unit

// File: doc/dist_sqrt_unit.md
Name: dist_sqrt_unit

Overview:
- Iterative integer square-root stage, directly downstream of the distance control unit. Consumes the accumulator's sum-of-squares and produces the Euclidean distance, floor(sqrt(DIN_Sqrt)).
- Uses a restoring digit-by-digit algorithm that resolves one result bit per clock.
- Uses a level handshake with the controller: the controller raises EN_Sqrt and holds it until RDY_Sqrt is seen, then drops EN_Sqrt.

Parameters:
- IN_WIDTH, 32: radicand width; must be even and at least 4.
- OUT_WIDTH, IN_WIDTH/2: derived localparam giving the root width. It is not overridable.

Ports:
- clk  input  1: single clock; all state updates on posedge.
- RST  input  1: synchronous, active-high reset.
- EN_Sqrt  input  1: start/hold level from the controller.
- DIN_Sqrt  input  IN_WIDTH: radicand (accumulator sum). Sampled only at capture.
- RDY_Sqrt  output  1: result valid; registered.
- DOUT_Sqrt  output  OUT_WIDTH: floor square root; registered.

Behaviour:
- Reset: state IDLE; RDY_Sqrt=0; DOUT_Sqrt=0; radicand, remainder, partial root and iteration counter all 0. RST overrides every other input, including mid-CALC; a reset during CALC produces no RDY_Sqrt.
- Internal registers:
  - rad: IN_WIDTH bits.
  - rem: OUT_WIDTH+2 bits.
  - root: OUT_WIDTH bits.
  - iter: clog2(OUT_WIDTH)+1 bits.
- IDLE:
  - RDY_Sqrt=0.
  - If EN_Sqrt=1 at the edge: rad<=DIN_Sqrt, rem<=0, root<=0, iter<=0, and go to CALC. This edge is the capture edge, E0.
  - Otherwise stay in IDLE.
- CALC, one step per edge:
  - r2 = {rem[OUT_WIDTH-1:0], rad[IN_WIDTH-1:IN_WIDTH-2]}
  - t = {root, 2'b01}
  - If r2>=t: rem<=r2-t and root<={root,1}. Otherwise rem<=r2 and root<={root,0}.
  - Then rad<=rad<<2 and iter<=iter+1.
  - On the step where iter==OUT_WIDTH-1: DOUT_Sqrt<=final root, RDY_Sqrt<=1, go to DONE.
  - If EN_Sqrt=0 at any CALC edge: abort. Go to IDLE, keep RDY_Sqrt=0, and leave DOUT_Sqrt unchanged. No step is performed on that edge.
- DONE:
  - RDY_Sqrt=1 and DOUT_Sqrt stable.
  - EN_Sqrt=1: stay in DONE. Never auto-restart.
  - EN_Sqrt=0: go to IDLE; RDY_Sqrt<=0.
- Latency:
  - RDY_Sqrt is high after edge E0+OUT_WIDTH, i.e. 16 cycles for the default width.
  - Throughput is one result per OUT_WIDTH+2 cycles minimum, because EN_Sqrt must be low for at least one edge to re-arm.
- DOUT_Sqrt holds the last completed root until the next successful completion. Returning to IDLE does not clear it.
- DIN_Sqrt changes after E0 have no effect.
- Arithmetic:
  - The remainder never exceeds 2*root+1, so OUT_WIDTH+2 bits suffice.
  - Comparison and subtraction are unsigned.
  - A zero radicand yields 0.
- Matching controller behaviour: the controller's EN_Sqrt drops one cycle after it observes RDY_Sqrt. The DONE->IDLE path therefore executes every vector, and RDY_Sqrt is high for 2 cycles per result.

Decomposition:
- Shared package dist_pkg:
  - sqrt state encodings SQ_IDLE=0, SQ_CALC=1, SQ_DONE=2 (2-bit).
  - DIST_SUM_WIDTH=32 and DIST_ROOT_WIDTH=16, shared with the accumulator and controller.
- One combinational sub-module, sqrt_iter_step:
  - Inputs: rem, root, 2 radicand bits.
  - Outputs: next rem, next root.
  - Unit-testable on its own; the top keeps the FSM, counter and registers.

Test Plan:
- Reset: RST=1 for 2 edges with EN_Sqrt=1 -> RDY_Sqrt=0, DOUT_Sqrt=0, no capture. After release, with EN high: capture on the first edge, RDY_Sqrt=1 after 16 further edges.
- Basic values: DIN=144 -> DOUT=12. DIN=15 -> DOUT=3 (floor). DIN=0 -> DOUT=0. DIN=1 -> DOUT=1. Each with RDY_Sqrt rising exactly at E0+16.
- Max: DIN=0xFFFFFFFF -> DOUT=0xFFFF; DIN=0xFFFE0001 -> DOUT=0xFFFF.
- Abort: capture DIN=1000000, drop EN at the 5th CALC edge -> RDY stays 0 and DOUT keeps its prior value. Re-raise EN with DIN=1000000 -> DOUT=1000 at E0+16.
- Hold and back-to-back: keep EN high 4 cycles in DONE -> RDY=1 and DOUT stable, no restart. Drop EN for 1 cycle, then apply DIN=49 -> RDY deasserts for 1 edge, then DOUT=7 after 16 more edges.
- Reset mid-CALC: assert RST at the 8th CALC step -> IDLE, RDY=0, DOUT=0 next edge, no late RDY.
